// File: rtl/mem_scan_pkg.sv
// rtl/mem_scan_pkg.sv - shared state encoding, sizes and init pattern for the memory scan sequencer
package mem_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_SCAN  = 2'd2,
    ST_PAUSE = 2'd3
  } scan_state_e;

  localparam int NUM_WORDS = 64;
  localparam int NUM_BYTES = 4;

  // Byte k of the identity word carries its own lane number above the word address.
  function automatic logic [31:0] init_word(input logic [5:0] addr, input logic [31:0] seed);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      w[8*k +: 8] = {2'(k), addr};
    end
    return w ^ seed;
  endfunction

endpackage

// File: rtl/mem_scan_pos.sv
// rtl/mem_scan_pos.sv - (word address, byte select) position counter, byte-minor order
module mem_scan_pos #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              adv_byte,
  input  logic              adv_word,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        cs,
  output logic              last_pos
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      cs   <= '0;
    end else if (clear) begin
      addr <= '0;
      cs   <= '0;
    end else if (adv_word) begin
      addr <= addr + 1'b1;
      cs   <= '0;
    end else if (adv_byte) begin
      // The CS carry rolls straight into the word address.
      {addr, cs} <= {addr, cs} + 1'b1;
    end
  end

  assign last_pos = (&addr) & (&cs);

endmodule

// File: rtl/mem_scan_ctrl.sv
// rtl/mem_scan_ctrl.sv - scan sequencer top; optional memory pre-fill under MEM_SCAN_INIT_EN
import mem_scan_pkg::*;

module mem_scan_ctrl #(
  parameter int          ADDR_W       = 6,
  parameter int          DATA_W       = 32,
  parameter int          DWELL_CYCLES = 4,
  parameter logic [31:0] INIT_SEED    = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Init_Req,
  input  logic              Pause,
  input  logic              Step,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [1:0]        CS,
  output logic              Mem_Write,
  output logic [DATA_W-1:0] Mem_Wdata,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clr, adv_byte, adv_word, last_pos, done_d;

  mem_scan_pos #(.ADDR_W(ADDR_W)) u_pos (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clear    (clr),
    .adv_byte (adv_byte),
    .adv_word (adv_word),
    .addr     (Mem_Addr),
    .cs       (CS),
    .last_pos (last_pos)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr      = 1'b0;
    adv_byte = 1'b0;
    adv_word = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          clr   = 1'b1;
          cnt_d = '0;
`ifdef MEM_SCAN_INIT_EN
          state_d = Init_Req ? ST_INIT : ST_SCAN;
`else
          state_d = ST_SCAN;
`endif
        end
      end
`ifdef MEM_SCAN_INIT_EN
      ST_INIT: begin
        if (&Mem_Addr) begin
          clr     = 1'b1;
          state_d = ST_SCAN;
        end else begin
          adv_word = 1'b1;
        end
      end
`endif
      ST_SCAN: begin
        // Pause takes priority over a dwell expiry in the same cycle.
        if (Pause) begin
          state_d = ST_PAUSE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (last_pos) begin
            done_d  = 1'b1;
            clr     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            adv_byte = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (Step) begin
          cnt_d = '0;
          if (last_pos) begin
            done_d  = 1'b1;
            clr     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            adv_byte = 1'b1;
            if (!Pause) state_d = ST_SCAN;
          end
        end else if (!Pause) begin
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      Busy    <= (state_d != ST_IDLE);
      Done    <= done_d;
    end
  end

`ifdef MEM_SCAN_INIT_EN
  logic [ADDR_W-1:0] wr_addr_d;

  // Write data is registered alongside the address it belongs to.
  assign wr_addr_d = (state_q == ST_INIT) ? Mem_Addr + 1'b1 : '0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Mem_Write <= 1'b0;
      Mem_Wdata <= '0;
    end else begin
      Mem_Write <= (state_d == ST_INIT);
      Mem_Wdata <= (state_d == ST_INIT) ? DATA_W'(init_word(6'(wr_addr_d), INIT_SEED)) : '0;
    end
  end
`else
  logic unused_init;

  assign unused_init = Init_Req ^ (^INIT_SEED);
  assign Mem_Write   = 1'b0;
  assign Mem_Wdata   = '0;
`endif

endmodule

// File: doc/mem_scan_ctrl.md
Name: mem_scan_ctrl

Overview:
Sequencer for the 64x32 storage block, which is addressed by Mem_Addr[5:0] with byte select CS[1:0] driving the 8-bit LED.
- Walks every (word, byte) position in address-major, byte-minor order.
- Holds each position for a programmable dwell so the LED byte can be observed or sampled.
- Optionally pre-fills memory with an identity pattern before the scan.
- Sits between board buttons/debouncers and the storage block; it is the only driver of the storage address, CS and write controls.

Parameters:
- ADDR_W, 6, storage word-address width (64 words).
- DATA_W, 32, storage word width (4 bytes).
- DWELL_CYCLES, 4, clocks each (addr, CS) position is held; legal range >= 1.
- INIT_SEED, 32'h0000_0000, XOR mask applied to the init pattern.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  single-cycle pulse; begins a run from IDLE; ignored while Busy=1.
- Init_Req  in  1  sampled with Start; 1 requests the INIT phase before SCAN.
- Pause  in  1  level; freezes the scan while high.
- Step  in  1  single-cycle pulse; advances one position while paused.
- Mem_Addr  out  ADDR_W  storage word address.
- CS  out  2  storage byte select.
- Mem_Write  out  1  storage write enable.
- Mem_Wdata  out  DATA_W  storage write data.
- Busy  out  1  high in INIT, SCAN or PAUSE.
- Done  out  1  one-cycle pulse at end of a run.

Behaviour:
- Reset (asynchronous, Rst_n=0):
  - State goes to IDLE immediately.
  - All outputs go to 0 immediately, including Mem_Write, even mid-write.
- All outputs are registered.
- IDLE:
  - Start=1 moves to INIT if Init_Req=1 and the feature is compiled in; otherwise moves to SCAN.
  - Mem_Addr=0, CS=0 on entry to either state.
  - Busy rises the cycle after Start.
  - Pause and Step are ignored.
- INIT:
  - One write per clock; Mem_Write=1, CS=0, Mem_Addr steps 0..63.
  - Mem_Wdata byte k (k=0..3) = {k[1:0], Mem_Addr}, then XOR with INIT_SEED.
  - Pause is ignored.
  - After the addr-63 write: Mem_Write=0, Mem_Addr=0, CS=0, go to SCAN. INIT lasts exactly 64 cycles.
- SCAN:
  - Dwell counter counts 0..DWELL_CYCLES-1.
  - On expiry the position advances: CS increments; when CS wraps from 3 to 0, Mem_Addr increments.
  - Expiry at (63,3): Done=1 for one cycle, Mem_Addr=0, CS=0, Busy=0, go to IDLE.
  - A full run is 256*DWELL_CYCLES cycles from SCAN entry.
  - Step is ignored in SCAN.
- Pause=1 in SCAN:
  - Next state is PAUSE; the dwell counter and position freeze.
  - Pause wins over a simultaneous dwell expiry: no advance.
- PAUSE:
  - Step=1 advances exactly one position and clears the dwell counter.
  - Step at (63,3) completes the run: Done pulse, go to IDLE.
  - Pause=0 returns to SCAN; the dwell resumes from the frozen count.
- Mem_Write is 0 in every state except INIT.
- DWELL_CYCLES=1: position advances every clock.
- Start while Busy: no effect on state or position.

Optional Feature:
- Macro MEM_SCAN_INIT_EN.
- Defined: INIT state, pattern generator and Mem_Wdata logic are present as above.
- Undefined:
  - INIT is removed and Init_Req is ignored; Start always goes to SCAN.
  - Mem_Write and Mem_Wdata are tied to 0.

Decomposition:
- Shared package mem_scan_pkg:
  - state encoding (IDLE, INIT, SCAN, PAUSE);
  - NUM_WORDS=64, NUM_BYTES=4;
  - init-pattern function (addr -> 32-bit word).
- Sub-module mem_scan_pos:
  - (Mem_Addr, CS) position counter with advance and clear inputs;
  - outputs last_pos, asserted at (63,3).

Test Plan:
- Reset, then Start with Init_Req=0, DWELL=4:
  - (0,0) is held 4 cycles, then (0,1), (0,2), (0,3), (1,0)...;
  - Done pulses once 1024 cycles after SCAN entry;
  - Mem_Write stays 0 throughout.
- Start with Init_Req=1, seed 0:
  - 64 consecutive writes;
  - at Mem_Addr=5, Mem_Wdata=32'hC585_4505;
  - at Mem_Addr=63, Mem_Wdata=32'hFFBF_7F3F;
  - SCAN starts at (0,0) the next cycle.
- Pause raised 2 cycles into (2,1) and held 10 cycles:
  - outputs stay at (2,1);
  - a Step moves to (2,2);
  - Pause=0 then gives a full 4-cycle dwell at (2,2).
- Pause raised in the same cycle as dwell expiry at (10,3):
  - no advance to (11,0) while Pause remains high.
- Rst_n pulsed low during INIT at Mem_Addr=30:
  - Mem_Write, Busy and Mem_Addr go to 0 immediately;
  - a new Start replays INIT from addr 0.
- Start pulsed mid-SCAN at (40,2):
  - sequence continues to (40,3) unchanged;
  - exactly one Done pulse at the end of the run.
